// File: rtl/lbpt_counter_table.sv
// LBPT counter storage: 2-bit saturating counters with an init sweep, registered lookups and a 2-stage update RMW.
// Optional macro LBPT_READ_BYPASS_EN: a lookup hitting the in-flight update returns the post-update counter.
module lbpt_counter_table #(
   parameter int         INDEX_WIDTH  = 10,
   parameter logic [1:0] INIT_COUNTER = 2'b01
) (
   input  logic                   CLK,
   input  logic                   RST,
   output logic                   ready,
   input  logic                   read_valid,
   input  logic [INDEX_WIDTH-1:0] read_index,
   output logic                   pred_valid,
   output logic                   pred_taken,
   output logic [1:0]             pred_counter,
   input  logic                   update_valid,
   input  logic [INDEX_WIDTH-1:0] update_index,
   input  logic                   update_taken
);

   localparam int DEPTH = 2 ** INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};
   localparam logic [INDEX_WIDTH-1:0] INDEX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                 state_r;
   logic [INDEX_WIDTH-1:0] sweep_ptr_r;
   logic [1:0]             table_mem [DEPTH];

   logic                   u2_valid_r;
   logic [INDEX_WIDTH-1:0] u2_index_r;
   logic                   u2_taken_r;
   logic [1:0]             u2_old_r;

   logic [1:0]             u2_new_s;
   logic [1:0]             u1_old_s;
   logic [1:0]             read_value_s;
   logic                   accept_s;

   function automatic logic [1:0] sat_inc(input logic [1:0] value);
      if (value == 2'b11) return 2'b11;
      else                return value + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] value);
      if (value == 2'b00) return 2'b00;
      else                return value - 2'b01;
   endfunction

   function automatic logic [1:0] next_counter(input logic [1:0] value, input logic taken);
      if (taken) return sat_inc(value);
      else       return sat_dec(value);
   endfunction

   // Next counter value, U1 forwarding from U2, and lookup source selection.
   always_comb begin
      accept_s = (state_r == ST_READY);
      u2_new_s = next_counter(u2_old_r, u2_taken_r);
      if (u2_valid_r && (u2_index_r == update_index)) u1_old_s = u2_new_s;
      else                                            u1_old_s = table_mem[update_index];
`ifdef LBPT_READ_BYPASS_EN
      if (u2_valid_r && (u2_index_r == read_index)) read_value_s = u2_new_s;
      else                                          read_value_s = table_mem[read_index];
`else
      read_value_s = table_mem[read_index];
`endif
   end

   // Init sweep / ready state machine.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r     <= ST_INIT;
         sweep_ptr_r <= {INDEX_WIDTH{1'b0}};
         ready       <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (sweep_ptr_r == LAST_INDEX) begin
                  state_r <= ST_READY;
                  ready   <= 1'b1;
               end else begin
                  sweep_ptr_r <= sweep_ptr_r + INDEX_ONE;
                  ready       <= 1'b0;
               end
            end
            ST_READY: begin
               ready <= 1'b1;
            end
            default: begin
               state_r     <= ST_INIT;
               sweep_ptr_r <= {INDEX_WIDTH{1'b0}};
               ready       <= 1'b0;
            end
         endcase
      end
   end

   // Registered lookup result; counter holds when no lookup is accepted.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pred_valid   <= 1'b0;
         pred_taken   <= 1'b0;
         pred_counter <= 2'b00;
      end else if (accept_s && read_valid) begin
         pred_valid   <= 1'b1;
         pred_taken   <= read_value_s[1];
         pred_counter <= read_value_s;
      end else begin
         pred_valid   <= 1'b0;
      end
   end

   // U1 -> U2 stage register: captures request and the (possibly forwarded) old counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         u2_valid_r <= 1'b0;
         u2_index_r <= {INDEX_WIDTH{1'b0}};
         u2_taken_r <= 1'b0;
         u2_old_r   <= 2'b00;
      end else if (accept_s && update_valid) begin
         u2_valid_r <= 1'b1;
         u2_index_r <= update_index;
         u2_taken_r <= update_taken;
         u2_old_r   <= u1_old_s;
      end else begin
         u2_valid_r <= 1'b0;
      end
   end

   // Table array: sweep writes during INIT, U2 write-back during READY; contents are rebuilt after every reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         // no write while reset is held
      end else if (state_r == ST_INIT) begin
         table_mem[sweep_ptr_r] <= INIT_COUNTER;
      end else if (u2_valid_r) begin
         table_mem[u2_index_r] <= u2_new_s;
      end else begin
         // idle: contents hold
      end
   end

endmodule

// File: tb/tb_lbpt_counter_table.sv
// Directed bench for lbpt_counter_table (INDEX_WIDTH=4) with a lookup scoreboard queue.
module tb_lbpt_counter_table;

   localparam int IW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          ready;
   logic          read_valid = 1'b0;
   logic [IW-1:0] read_index = '0;
   logic          pred_valid;
   logic          pred_taken;
   logic [1:0]    pred_counter;
   logic          update_valid = 1'b0;
   logic [IW-1:0] update_index = '0;
   logic          update_taken = 1'b0;

   int         n_compared = 0;
   int         n_mismatched = 0;
   logic       accepting = 1'b0;
   logic [1:0] exp_q [$];
   logic [1:0] sat_up_exp [4];
   logic [1:0] sat_dn_exp [4];
   logic [1:0] collide_exp;
   int         wait_cycles;

   lbpt_counter_table #(.INDEX_WIDTH(IW), .INIT_COUNTER(2'b01)) dut (
      .CLK(CLK), .RST(RST), .ready(ready),
      .read_valid(read_valid), .read_index(read_index),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_counter(pred_counter),
      .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Lookup monitor: pred_valid must follow an accepted read by exactly one cycle.
   always @(posedge CLK) begin
      logic exp_pv;
      logic [1:0] exp_cnt;
      exp_pv = read_valid && accepting;
      #1;
      check("pred_valid", {1'b0, pred_valid}, {1'b0, exp_pv});
      if (pred_valid && exp_pv) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 2'b01, 2'b00);
         end else begin
            exp_cnt = exp_q.pop_front();
            check("pred_counter", pred_counter, exp_cnt);
            check("pred_taken", {1'b0, pred_taken}, {1'b0, exp_cnt[1]});
         end
      end
   end

   task automatic rd(input logic [IW-1:0] idx, input logic [1:0] exp);
      read_valid = 1'b1;
      read_index = idx;
      exp_q.push_back(exp);
      @(negedge CLK);
      read_valid = 1'b0;
   endtask

   task automatic upd(input logic [IW-1:0] idx, input logic taken);
      update_valid = 1'b1;
      update_index = idx;
      update_taken = taken;
      @(negedge CLK);
      update_valid = 1'b0;
   endtask

   initial begin
      sat_up_exp = '{2'b10, 2'b11, 2'b11, 2'b11};
      sat_dn_exp = '{2'b10, 2'b01, 2'b00, 2'b00};
`ifdef LBPT_READ_BYPASS_EN
      collide_exp = 2'b10;
`else
      collide_exp = 2'b01;
`endif

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_ready", {1'b0, ready}, 2'b00);
      check("rst_pred_valid", {1'b0, pred_valid}, 2'b00);
      check("rst_pred_counter", pred_counter, 2'b00);
      RST = 1'b0;

      // Init sweep: 16 cycles not ready, requests ignored
      for (int i = 0; i < 16; i++) begin
         check("init_ready_low", {1'b0, ready}, 2'b00);
         read_valid   = 1'b1;
         read_index   = i[IW-1:0];
         update_valid = 1'b1;
         update_index = 4'd2;
         update_taken = 1'b1;
         @(negedge CLK);
      end
      read_valid   = 1'b0;
      update_valid = 1'b0;
      check("init_ready_high", {1'b0, ready}, 2'b01);
      accepting = 1'b1;

      // All entries weakly not-taken (index 2 untouched by ignored update)
      for (int i = 0; i < 16; i++) begin
         read_valid = 1'b1;
         read_index = i[IW-1:0];
         exp_q.push_back(2'b01);
         @(negedge CLK);
      end
      read_valid = 1'b0;
      @(negedge CLK);
      check("hold_counter", pred_counter, 2'b01);

      // Saturation up then down on index 3
      for (int i = 0; i < 4; i++) begin
         upd(4'd3, 1'b1);
         @(negedge CLK);
         rd(4'd3, sat_up_exp[i]);
      end
      for (int i = 0; i < 4; i++) begin
         upd(4'd3, 1'b0);
         @(negedge CLK);
         rd(4'd3, sat_dn_exp[i]);
      end

      // Back-to-back updates to index 5
      update_valid = 1'b1;
      update_index = 4'd5;
      update_taken = 1'b1;
      repeat (3) @(negedge CLK);
      update_valid = 1'b0;
      repeat (2) @(negedge CLK);
      rd(4'd5, 2'b11);

      // Read/write collision on index 7
      upd(4'd7, 1'b1);
      rd(4'd7, collide_exp);
      rd(4'd7, 2'b10);

      // Independent read and update on different indices
      update_valid = 1'b1;
      update_index = 4'd8;
      update_taken = 1'b0;
      read_valid   = 1'b1;
      read_index   = 4'd6;
      exp_q.push_back(2'b01);
      @(negedge CLK);
      update_valid = 1'b0;
      read_valid   = 1'b0;
      @(negedge CLK);
      rd(4'd8, 2'b00);
      rd(4'd6, 2'b01);

      // Reset during the U2 cycle of an update to index 9
      upd(4'd9, 1'b1);
      accepting = 1'b0;
      #2 RST = 1'b1;
      #1;
      check("midrst_ready", {1'b0, ready}, 2'b00);
      check("midrst_pred_valid", {1'b0, pred_valid}, 2'b00);
      check("midrst_pred_counter", pred_counter, 2'b00);
      check("midrst_pred_taken", {1'b0, pred_taken}, 2'b00);
      @(negedge CLK);
      RST = 1'b0;
      wait_cycles = 0;
      while (!ready && wait_cycles < 40) begin
         @(negedge CLK);
         wait_cycles++;
      end
      check("resweep_cycles", wait_cycles[1:0], 2'b00);
      n_compared++;
      assert (wait_cycles == 16) else begin
         n_mismatched++;
         $error("FAIL resweep_len observed=%0d expected=16", wait_cycles);
      end
      accepting = 1'b1;
      rd(4'd9, 2'b01);
      rd(4'd3, 2'b01);
      rd(4'd5, 2'b01);

      repeat (3) @(negedge CLK);
      n_compared++;
      assert (exp_q.size() == 0) else begin
         n_mismatched++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
